// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues in-order fetches with credit accounting and buffers returned words for Decode.
// Optional FETCH_QUEUE_BYPASS_EN presents a response to Decode in its arrival cycle when the queue is empty.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req_valid,
  output logic [31:0]              imem_req_addr,
  input  logic                     imem_req_ready,
  input  logic                     imem_rsp_valid,
  input  logic [31:0]              imem_rsp_data,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     StallD,
  output logic [31:0]              instrD,
  output logic [31:0]              PCD,
  output logic [31:0]              PCPlus4D,
  output logic                     validD,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [31:0] START_PC = RESET_PC & 32'hFFFF_FFFC;

  logic [31:0]   fetchPc;
  logic [1:0]    outstanding;
  logic [1:0]    discard;
  logic [CW-1:0] cnt;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [31:0]   instrMem [DEPTH];
  logic [31:0]   pcMem    [DEPTH];

  logic          handshake;
  logic          rspAccept;
  logic          bypassHit;
  logic          enq;
  logic          deq;
  logic [CW:0]   occupied;
  logic [31:0]   rspPc;
  logic [31:0]   redirectTarget;

  assign occupied       = (CW+1)'(cnt) + (CW+1)'(outstanding);
  assign imem_req_valid = reset && (occupied < (CW+1)'(DEPTH)) && (outstanding < 2'd2) && !redirect;
  assign imem_req_addr  = fetchPc;
  assign handshake      = imem_req_valid && imem_req_ready;
  assign redirectTarget = redirect_pc & 32'hFFFF_FFFC;

  // Oldest live request: skip the stale ones still owed, counting back from fetchPc.
  assign rspPc = fetchPc - {28'd0, outstanding - discard, 2'b00};

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypassHit = reset && (cnt == '0) && (discard == '0) && imem_rsp_valid && !redirect;
`else
  assign bypassHit = 1'b0;
`endif

  assign rspAccept = imem_rsp_valid && (discard == '0) && !redirect;
  assign enq       = rspAccept && !(bypassHit && !StallD);
  assign deq       = (cnt != '0) && !StallD && !redirect;
  assign count     = cnt;

  always_comb begin
    validD   = 1'b0;
    instrD   = '0;
    PCD      = '0;
    PCPlus4D = '0;
    if (bypassHit) begin
      validD   = 1'b1;
      instrD   = imem_rsp_data;
      PCD      = rspPc;
      PCPlus4D = rspPc + 32'd4;
    end else if (cnt != '0) begin
      validD   = 1'b1;
      instrD   = instrMem[head];
      PCD      = pcMem[head];
      PCPlus4D = pcMem[head] + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetchPc     <= START_PC;
      outstanding <= '0;
      discard     <= '0;
      cnt         <= '0;
      head        <= '0;
      tail        <= '0;
    end else begin
      case ({handshake, imem_rsp_valid})
        2'b10:   outstanding <= outstanding + 2'd1;
        2'b01:   outstanding <= outstanding - 2'd1;
        default: outstanding <= outstanding;
      endcase

      if (redirect) begin
        fetchPc <= redirectTarget;
        cnt     <= '0;
        head    <= '0;
        tail    <= '0;
        discard <= outstanding - {1'b0, imem_rsp_valid};
      end else begin
        if (handshake)
          fetchPc <= fetchPc + 32'd4;
        if (imem_rsp_valid && (discard != '0))
          discard <= discard - 2'd1;
        if (enq)
          tail <= tail + PW'(1);
        if (deq)
          head <= head + PW'(1);
        case ({enq, deq})
          2'b10:   cnt <= cnt + CW'(1);
          2'b01:   cnt <= cnt - CW'(1);
          default: cnt <= cnt;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      instrMem[tail] <= imem_rsp_data;
      pcMem[tail]    <= rspPc;
    end
  end

endmodule
